fix_mult_arb: RTL and testbench
===============================

// Module: fix_mult_arb
// PURPOSE
//  Shares one fix_mult instance (SHIFT_MODE=2, runtime shift) between N_REQ requesters.
//  Round-robin arbitration with bounded bursts; one operation issued per cycle, fully pipelined.
//  A tag pipeline matched to the multiplier latency steers each result back to its requester.
//  Sits between the DSP lane controllers and the shared fixed-point multiplier.
// PARAMETERS
//  N_REQ      4   number of requesters (>=2)
//  IN_WIDTH   16  operand width, two's complement
//  OUT_WIDTH  16  result width after shift/saturate
//  MULT_PIPE  1   fix_mult MULT_PIPE (>=1 required)
//  SHIFT_PIPE 1   fix_mult SHIFT_PIPE
//  SAT_PIPE   1   fix_mult SAT_PIPE
//  BURST_LEN  4   max consecutive accepts by one owner (>=1; 1 = pure round robin)
// PORTS
//  clk        in   1                      clock
//  rst_n      in   1                      synchronous active-low reset
//  req_valid  in   N_REQ                  per-requester operation valid
//  req_ready  out  N_REQ                  per-requester accept (at most one bit high)
//  req_opa    in   N_REQ*IN_WIDTH         operand A, requester i at [i*IN_WIDTH +: IN_WIDTH]
//  req_opb    in   N_REQ*IN_WIDTH         operand B, same packing
//  req_shift  in   N_REQ*SW               shift amount, SW=$clog2(2*IN_WIDTH)
//  rsp_valid  out  N_REQ                  one-hot result strobe, no backpressure
//  rsp_data   out  OUT_WIDTH              result, valid where rsp_valid != 0
//  busy       out  1                      any operation in flight
// BEHAVIOUR
//  - One clock; reset synchronous active-low. Reset: state=IDLE, rr_ptr=0, owner=0, cnt=0,
//    all tag-pipe valids 0. Outputs: rsp_valid=0, busy=0, req_ready=0 while rst_n=0.
//  - LAT = MULT_PIPE+SHIFT_PIPE+SAT_PIPE. Accept (req_valid[i]&req_ready[i]) in cycle t ->
//    rsp_valid[i]=1 with rsp_data=sat((opa*opb)>>>shift) in cycle t+LAT. Throughput 1/cycle.
//  - req_ready is combinational from state regs and req_valid; never depends on rsp side.
//  - Chosen requester c:
//      OWN && req_valid[owner] && cnt<BURST_LEN -> c=owner
//      else c = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//    req_ready[c]=1 only if req_valid[c]; no valid -> req_ready=0, no issue.
//  - FSM IDLE/OWN:
//      accept by owner in OWN: cnt++; cnt reaches BURST_LEN -> IDLE.
//      accept by rr pick: owner<=c, cnt<=1, rr_ptr<=(c+1) mod N_REQ (N_REQ-1 wraps to 0);
//        next state OWN if BURST_LEN>1 else IDLE.
//      OWN and owner drops valid or cnt==BURST_LEN: rr pick same cycle, no bubble cycle.
//      no accept in IDLE: hold.
//  - Mux drives fix_mult opa/opb/shift_amount from c; idle cycles drive zeros.
//  - Tag pipe: LAT stages of {valid, id}; rsp_valid = onehot(id) & valid at stage LAT.
//  - rsp_data holds the last result when no strobe.
//  - busy = OR of tag-pipe valids.
//  - Simultaneous accept and response for the same requester are both legal.
//  - Reset mid-operation clears all in-flight tags; those results are never reported.
// CONFIGURATION
//  FIX_MULT_ARB_STATS_EN defined: extra port grant_cnt out N_REQ*16. Per-requester
//    accept counter, saturating at 16'hFFFF, cleared by reset.
//  Undefined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  fix_pkg: SW width function, fix_arb_state_e {IDLE, OWN}, LAT computation function.
//  Sub-module fix_rr_pick: combinational first-valid-from-pointer search.
//  Instances: fix_mult (SHIFT_MODE=2) and pipe_reg (WIDTH=1+$clog2(N_REQ), STAGE=LAT).
// TESTING
//  1. req_valid=4'b0001, opa=16'h0100, opb=16'h0200, shift=8; defaults (LAT=3)
//     -> rsp_valid=0001, rsp_data=16'h0200 three cycles later.
//  2. All 4 valid continuously, BURST_LEN=4
//     -> grants 0,0,0,0,1,1,1,1,2,...,3, then wrap to 0; one accept every cycle.
//  3. Owner 2 drops valid after 2 accepts, req 3 valid
//     -> req 3 granted in the same cycle; later rsp strobes in accept order, id-correct.
//  4. opa=16'h7FFF, opb=16'h7FFF, shift=0 -> rsp_data=16'h7FFF (saturation);
//     opa=16'h8000, opb=16'h7FFF, shift=0 -> rsp_data=16'h8000.
//  5. rst_n low for 1 cycle with 3 ops in flight
//     -> no rsp_valid afterwards, busy=0, next grant starts from requester 0.
//  6. STATS_EN defined: 10 accepts by requester 1 -> grant_cnt[31:16]=10; others 0.

Source files
------------

// File: rtl/fix_pkg.sv
// Shared types and helpers for the fix_mult arbiter slice.
// Width and latency helpers plus the arbiter state encoding.
package fix_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } fix_arb_state_e;

    function automatic int sw_width(input int in_w);
        return $clog2(2 * in_w);
    endfunction

    function automatic int lat_calc(input int mp, input int sp, input int tp);
        return mp + sp + tp;
    endfunction

endpackage

// File: rtl/fix_mult_arb_if.sv
// Request/response bundle between lane controllers and the arbiter.
// master = requester side, slave = arbiter side.
interface fix_mult_arb_if import fix_pkg::*; #(
    parameter int N_REQ     = 4,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16,
    parameter int SW        = sw_width(IN_WIDTH)
);
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ*IN_WIDTH-1:0] req_opa;
    logic [N_REQ*IN_WIDTH-1:0] req_opb;
    logic [N_REQ*SW-1:0]       req_shift;
    logic [N_REQ-1:0]          rsp_valid;
    logic [OUT_WIDTH-1:0]      rsp_data;
    logic                      busy;

    modport master (
        output req_valid, req_opa, req_opb, req_shift,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_opa, req_opb, req_shift,
        output req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/fix_mult.sv
// Pipelined signed multiply, arithmetic right shift, saturate.
// SHIFT_MODE=2 takes the shift per operation; else SHIFT_CONST.
module fix_mult import fix_pkg::*; #(
    parameter int IN_WIDTH    = 16,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT_MODE  = 2,
    parameter int SHIFT_CONST = 0,
    parameter int MULT_PIPE   = 1,
    parameter int SHIFT_PIPE  = 1,
    parameter int SAT_PIPE    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [IN_WIDTH-1:0]           opa,
    input  logic [IN_WIDTH-1:0]           opb,
    input  logic [sw_width(IN_WIDTH)-1:0] shift_amount,
    output logic [OUT_WIDTH-1:0]          result
);
    localparam int SW = sw_width(IN_WIDTH);
    localparam int PW = 2 * IN_WIDTH;
    localparam logic signed [PW-1:0] MAXV =
        {{(PW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = ~MAXV;

    logic signed [PW-1:0] prod, prod_p, shd, shd_p;
    logic [PW+SW-1:0]     mp_out;
    logic [SW-1:0]        sh_p, sh_use;
    logic [OUT_WIDTH-1:0] sat;

    assign prod = $signed(opa) * $signed(opb);

    pipe_reg #(.WIDTH(PW+SW), .STAGE(MULT_PIPE)) u_mp (
        .clk(clk), .rst_n(rst_n),
        .in_data({prod, shift_amount}), .out_data(mp_out)
    );

    assign prod_p = mp_out[PW+SW-1:SW];
    assign sh_p   = mp_out[SW-1:0];
    assign sh_use = (SHIFT_MODE == 2) ? sh_p : SW'(SHIFT_CONST);
    assign shd    = prod_p >>> sh_use;

    pipe_reg #(.WIDTH(PW), .STAGE(SHIFT_PIPE)) u_sp (
        .clk(clk), .rst_n(rst_n), .in_data(shd), .out_data(shd_p)
    );

    // clamp the shifted product into the signed output range
    always_comb begin
        sat = shd_p[OUT_WIDTH-1:0];
        if (shd_p > MAXV)      sat = MAXV[OUT_WIDTH-1:0];
        else if (shd_p < MINV) sat = MINV[OUT_WIDTH-1:0];
    end

    pipe_reg #(.WIDTH(OUT_WIDTH), .STAGE(SAT_PIPE)) u_tp (
        .clk(clk), .rst_n(rst_n), .in_data(sat), .out_data(result)
    );
endmodule

// File: rtl/fix_rr_pick.sv
// First asserted valid bit, scanning upward from ptr with wrap.
// Purely combinational.
module fix_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] cand;

    // walk backwards so the candidate closest to ptr wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/pipe_reg.sv
// Plain delay line of STAGE registers, cleared by reset.
// STAGE=0 degenerates to a wire.
module pipe_reg #(
    parameter int WIDTH = 1,
    parameter int STAGE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data
);
    if (STAGE == 0) begin : g_wire
        assign out_data = in_data;
    end else begin : g_pipe
        logic [WIDTH-1:0] stg_q [STAGE];
        logic [WIDTH-1:0] stg_d [STAGE];

        // shift each stage forward by one
        always_comb begin
            stg_d[0] = in_data;
            for (int k = 1; k < STAGE; k++) stg_d[k] = stg_q[k-1];
        end

        // stage registers
        always_ff @(posedge clk) begin
            for (int k = 0; k < STAGE; k++) begin
                if (!rst_n) stg_q[k] <= '0;
                else        stg_q[k] <= stg_d[k];
            end
        end

        assign out_data = stg_q[STAGE-1];
    end
endmodule

// File: rtl/fix_mult_arb.sv
// Round-robin burst arbiter sharing one fix_mult among N_REQ lanes.
// Optional FIX_MULT_ARB_STATS_EN adds per-lane accept counters.
module fix_mult_arb import fix_pkg::*; #(
    parameter int N_REQ      = 4,
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int MULT_PIPE  = 1,
    parameter int SHIFT_PIPE = 1,
    parameter int SAT_PIPE   = 1,
    parameter int BURST_LEN  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fix_mult_arb_if.slave bus
`ifdef FIX_MULT_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0] grant_cnt
`endif
);
    localparam int SW  = sw_width(IN_WIDTH);
    localparam int LAT = lat_calc(MULT_PIPE, SHIFT_PIPE, SAT_PIPE);
    localparam int IW  = $clog2(N_REQ);
    localparam int CW  = $clog2(BURST_LEN + 1);
    localparam int TW  = 1 + IW;
    localparam int FW  = $clog2(LAT + 1);

    fix_arb_state_e       state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d, rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [FW-1:0]        infl_q, infl_d;
    logic [OUT_WIDTH-1:0] hold_q, hold_d, mult_res;
    logic [IW-1:0]        pick_idx, sel;
    logic                 pick_found, own_hit, accept, rsp_fire;
    logic [IN_WIDTH-1:0]  mux_a, mux_b;
    logic [SW-1:0]        mux_sh;
    logic [TW-1:0]        tag_out;

    fix_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .valid(bus.req_valid), .ptr(rr_ptr_q),
        .found(pick_found), .idx(pick_idx)
    );

    assign own_hit = (state_q == OWN) && bus.req_valid[owner_q]
                     && (cnt_q < CW'(BURST_LEN));

    // choose the requester and drive its ready and operands
    always_comb begin
        sel    = own_hit ? owner_q : pick_idx;
        accept = rst_n && (own_hit || pick_found);
        bus.req_ready = '0;
        mux_a  = '0;
        mux_b  = '0;
        mux_sh = '0;
        if (accept) begin
            bus.req_ready[sel] = 1'b1;
            mux_a  = bus.req_opa[sel*IN_WIDTH +: IN_WIDTH];
            mux_b  = bus.req_opb[sel*IN_WIDTH +: IN_WIDTH];
            mux_sh = bus.req_shift[sel*SW +: SW];
        end
    end

    // burst ownership and round-robin pointer update
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (own_hit) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == CW'(BURST_LEN)) state_d = IDLE;
            end else begin
                owner_d  = pick_idx;
                cnt_d    = CW'(1);
                rr_ptr_d = (pick_idx == IW'(N_REQ - 1)) ? '0
                           : pick_idx + 1'b1;
                state_d  = (BURST_LEN > 1) ? OWN : IDLE;
            end
        end
    end

    fix_mult #(
        .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT_MODE(2),
        .MULT_PIPE(MULT_PIPE), .SHIFT_PIPE(SHIFT_PIPE), .SAT_PIPE(SAT_PIPE)
    ) u_mult (
        .clk(clk), .rst_n(rst_n), .opa(mux_a), .opb(mux_b),
        .shift_amount(mux_sh), .result(mult_res)
    );

    pipe_reg #(.WIDTH(TW), .STAGE(LAT)) u_tag (
        .clk(clk), .rst_n(rst_n),
        .in_data({accept, sel}), .out_data(tag_out)
    );

    assign rsp_fire = rst_n && tag_out[TW-1];

    // steer the result, hold the last one, track in-flight tags
    always_comb begin
        hold_d = rsp_fire ? mult_res : hold_q;
        infl_d = infl_q + FW'(accept) - FW'(rsp_fire);
        bus.rsp_valid = '0;
        if (rsp_fire) bus.rsp_valid[tag_out[IW-1:0]] = 1'b1;
        bus.rsp_data = hold_d;
        bus.busy     = rst_n && (infl_q != '0);
    end

    // arbiter and response state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            infl_q   <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            infl_q   <= infl_d;
            hold_q   <= hold_d;
        end
    end

`ifdef FIX_MULT_ARB_STATS_EN
    logic [15:0] gcnt_q [N_REQ];
    logic [15:0] gcnt_d [N_REQ];

    // saturating per-requester accept counters
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            gcnt_d[i] = gcnt_q[i];
            if (accept && sel == IW'(i) && gcnt_q[i] != 16'hFFFF)
                gcnt_d[i] = gcnt_q[i] + 16'd1;
            grant_cnt[i*16 +: 16] = gcnt_q[i];
        end
    end

    // counter registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (!rst_n) gcnt_q[i] <= '0;
            else        gcnt_q[i] <= gcnt_d[i];
        end
    end
`endif
endmodule

// File: tb/tb_fix_mult_arb.sv
// Directed plus random bench for fix_mult_arb with a queue-based reference.
// Honours FIX_MULT_ARB_STATS_EN when defined.
module tb_fix_mult_arb;
    localparam int N   = 4;
    localparam int BL  = 4;
    localparam int LAT = 3;

    typedef struct {
        int          due;
        int          id;
        logic [15:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fix_mult_arb_if #(.N_REQ(N), .IN_WIDTH(16), .OUT_WIDTH(16)) bus ();

`ifdef FIX_MULT_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    fix_mult_arb #(
        .N_REQ(N), .IN_WIDTH(16), .OUT_WIDTH(16), .MULT_PIPE(1),
        .SHIFT_PIPE(1), .SAT_PIPE(1), .BURST_LEN(BL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef FIX_MULT_ARB_STATS_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          m_owner = -1;
    int          m_n = 0;
    int          m_next = 0;
    int          gcount[N];
    logic [15:0] last_d = '0;

    function automatic logic [15:0] ref_mul(logic [15:0] a, logic [15:0] b,
                                            logic [4:0] s);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> s;
        if (p > 32767) p = 32767;
        else if (p < -32768) p = -32768;
        return p[15:0];
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(logic [N-1:0] v);
        bus.req_valid = v;
        for (int i = 0; i < N; i++) begin
            bus.req_opa[i*16 +: 16] = 16'($urandom);
            bus.req_opb[i*16 +: 16] = 16'($urandom);
            bus.req_shift[i*5 +: 5] = 5'($urandom_range(0, 20));
        end
    endtask

    // check this cycle at the falling edge, then advance the model
    task automatic tick();
        int   g;
        bit   vo;
        int   c;
        exp_t e;
        #4;
        g  = -1;
        vo = 1'b0;
        if (rst_n) begin
            if (m_owner >= 0 && bus.req_valid[m_owner] && m_n < BL) begin
                g  = m_owner;
                vo = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    c = (m_next + k) % N;
                    if (g < 0 && bus.req_valid[c]) g = c;
                end
            end
        end
        chk("req_ready", 64'(bus.req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
        if (!rst_n) begin
            chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            chk("rst_busy", 64'(bus.busy), 64'd0);
        end else begin
            chk("busy", 64'(bus.busy), 64'(q.size() != 0));
            if (q.size() != 0 && q[0].due == cyc) begin
                chk("rsp_valid", 64'(bus.rsp_valid), 64'd1 << q[0].id);
                chk("rsp_data", 64'(bus.rsp_data), 64'(q[0].d));
                last_d = q[0].d;
                void'(q.pop_front());
            end else begin
                chk("rsp_idle", 64'(bus.rsp_valid), 64'd0);
                chk("rsp_hold", 64'(bus.rsp_data), 64'(last_d));
            end
        end
        if (!rst_n) begin
            q.delete();
            m_owner = -1;
            m_n     = 0;
            m_next  = 0;
            last_d  = '0;
            for (int i = 0; i < N; i++) gcount[i] = 0;
        end else if (g >= 0) begin
            e.due = cyc + LAT;
            e.id  = g;
            e.d   = ref_mul(bus.req_opa[g*16 +: 16], bus.req_opb[g*16 +: 16],
                            bus.req_shift[g*5 +: 5]);
            q.push_back(e);
            if (vo) begin
                m_n++;
                if (m_n == BL) m_owner = -1;
            end else begin
                m_owner = (BL > 1) ? g : -1;
                m_n     = 1;
                m_next  = (g + 1) % N;
            end
            if (gcount[g] < 65535) gcount[g]++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int n);
        rst_n = 1'b0;
        drive('0);
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    task automatic idle(int n);
        drive('0);
        repeat (n) tick();
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_opa   = '0;
        bus.req_opb   = '0;
        bus.req_shift = '0;
        @(posedge clk);
        #1;
        do_reset(2);

        // single op from requester 0
        drive(4'b0001);
        bus.req_opa[15:0] = 16'h0100;
        bus.req_opb[15:0] = 16'h0200;
        bus.req_shift[4:0] = 5'd8;
        tick();
        idle(5);

        // all lanes busy: bursts of BL then rotate
        do_reset(1);
        repeat (24) begin
            drive(4'b1111);
            tick();
        end
        idle(5);

        // owner 2 drops after two accepts, lane 3 takes over at once
        do_reset(1);
        drive(4'b1100);
        tick();
        drive(4'b1100);
        tick();
        drive(4'b1000);
        tick();
        drive(4'b1000);
        tick();
        idle(5);

        // saturation corners
        drive(4'b0001);
        bus.req_opa[15:0] = 16'h7FFF;
        bus.req_opb[15:0] = 16'h7FFF;
        bus.req_shift[4:0] = 5'd0;
        tick();
        drive(4'b0001);
        bus.req_opa[15:0] = 16'h8000;
        bus.req_opb[15:0] = 16'h7FFF;
        bus.req_shift[4:0] = 5'd0;
        tick();
        idle(5);

        // random traffic
        repeat (300) begin
            drive(4'($urandom));
            tick();
        end
        idle(5);

        // reset with operations in flight
        repeat (3) begin
            drive(4'b1111);
            tick();
        end
        do_reset(1);
        idle(LAT + 2);
        drive(4'b1111);
        tick();
        idle(6);

`ifdef FIX_MULT_ARB_STATS_EN
        do_reset(1);
        repeat (10) begin
            drive(4'b0010);
            tick();
        end
        idle(5);
        for (int i = 0; i < N; i++)
            chk("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(gcount[i]));
`endif

        chk("sb_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
